// File: rtl/result_dump_pkg.sv
// Shared types and constants for the result_dump readout stage.
// RESULT_DUMP_CHECKSUM_EN selects the 34-byte framed variant with a trailing XOR byte.
package result_dump_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam int unsigned REG_W     = 12;
  localparam int unsigned NUM_REGS  = 16;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

`ifdef RESULT_DUMP_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 34;
`else
  localparam int unsigned FRAME_LEN = 33;
`endif

endpackage

// File: rtl/result_dump_byte_sel.sv
// Maps a frame byte index onto the header, a register nibble/byte, or the checksum.
// RESULT_DUMP_CHECKSUM_EN adds the XOR byte at index 2*NUM_REGS+1.
module result_byte_sel #(
  parameter int unsigned REG_W     = result_dump_pkg::REG_W,
  parameter int unsigned NUM_REGS  = result_dump_pkg::NUM_REGS,
  parameter logic [7:0]  SYNC_BYTE = result_dump_pkg::SYNC_BYTE
) (
  input  logic [NUM_REGS*REG_W-1:0] snap,
  input  logic [5:0]                idx,
  output logic [7:0]                byte_out
);
  import result_dump_pkg::*;

  logic [5:0]       data_idx;
  logic [REG_W-1:0] reg_sel;

  // Data bytes start at index 1: even offsets carry the high nibble, odd the low byte.
  assign data_idx = idx - 6'd1;

  always_comb begin
    reg_sel = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (data_idx[5:1] == 5'(k)) reg_sel = snap[k*REG_W +: REG_W];
    end
  end

`ifdef RESULT_DUMP_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      csum = csum ^ {4'h0, snap[k*REG_W+8 +: 4]} ^ snap[k*REG_W +: 8];
    end
  end
`endif

  always_comb begin
    byte_out = '0;
    if (idx == '0) begin
      byte_out = SYNC_BYTE;
    end else if (idx <= 6'(2*NUM_REGS)) begin
      byte_out = data_idx[0] ? reg_sel[7:0] : {4'h0, reg_sel[REG_W-1:8]};
    end
`ifdef RESULT_DUMP_CHECKSUM_EN
    else if (idx == 6'(2*NUM_REGS + 1)) begin
      byte_out = csum;
    end
`endif
  end

endmodule

// File: rtl/result_dump.sv
// Snapshots r1..r16 on the rising edge of end_process and streams them as a framed
// valid/ready byte sequence. RESULT_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module result_dump #(
  parameter int unsigned REG_W     = result_dump_pkg::REG_W,
  parameter int unsigned NUM_REGS  = result_dump_pkg::NUM_REGS,
  parameter logic [7:0]  SYNC_BYTE = result_dump_pkg::SYNC_BYTE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] r1,
  input  logic [REG_W-1:0] r2,
  input  logic [REG_W-1:0] r3,
  input  logic [REG_W-1:0] r4,
  input  logic [REG_W-1:0] r5,
  input  logic [REG_W-1:0] r6,
  input  logic [REG_W-1:0] r7,
  input  logic [REG_W-1:0] r8,
  input  logic [REG_W-1:0] r9,
  input  logic [REG_W-1:0] r10,
  input  logic [REG_W-1:0] r11,
  input  logic [REG_W-1:0] r12,
  input  logic [REG_W-1:0] r13,
  input  logic [REG_W-1:0] r14,
  input  logic [REG_W-1:0] r15,
  input  logic [REG_W-1:0] r16,
  input  logic             end_process,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             dump_done
);
  import result_dump_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  state_t                    state, state_d;
  logic                      end_q;
  logic                      rise;
  logic [5:0]                idx, idx_d, idx_nxt;
  logic [NUM_REGS*REG_W-1:0] snap, snap_d, live;
  logic [7:0]                tx_data_d, sel_byte;
  logic                      tx_valid_d, busy_d, dump_done_d;

  assign live    = {r16, r15, r14, r13, r12, r11, r10, r9, r8, r7, r6, r5, r4, r3, r2, r1};
  assign rise    = end_process & ~end_q;
  assign idx_nxt = idx + 6'd1;

  // The byte after the current one is looked up so it can be registered on the handshake edge.
  result_byte_sel #(
    .REG_W    (REG_W),
    .NUM_REGS (NUM_REGS),
    .SYNC_BYTE(SYNC_BYTE)
  ) u_byte_sel (
    .snap    (snap),
    .idx     (idx_nxt),
    .byte_out(sel_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      end_q     <= 1'b0;
      idx       <= '0;
      snap      <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      state     <= state_d;
      end_q     <= end_process;
      idx       <= idx_d;
      snap      <= snap_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      busy      <= busy_d;
      dump_done <= dump_done_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    snap_d      = snap;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    busy_d      = busy;
    dump_done_d = dump_done;
    unique case (state)
      IDLE: begin
        if (rise) begin
          snap_d     = live;
          idx_d      = '0;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == LAST_IDX) begin
            idx_d       = '0;
            tx_data_d   = '0;
            tx_valid_d  = 1'b0;
            busy_d      = 1'b0;
            dump_done_d = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = sel_byte;
          end
        end
      end
      DONE: begin
        if (!end_process) begin
          dump_done_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_dump.sv
// Scoreboard bench for result_dump: expected frames are queued at stimulus time and
// popped at every observed handshake. Define RESULT_DUMP_CHECKSUM_EN to cover the checksum build.
module tb_result_dump;

`ifdef RESULT_DUMP_CHECKSUM_EN
  localparam int EXP_LEN = 34;
`else
  localparam int EXP_LEN = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rv [16];
  logic        end_process;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        dump_done;

  int         checks   = 0;
  int         failures = 0;
  int         xfers    = 0;
  logic [7:0] exp_q [$];
  logic       rand_ready = 1'b0;
  logic       hold_pend  = 1'b0;
  logic [7:0] held       = '0;

  always #5 clk = ~clk;

  result_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r1         (rv[0]),
    .r2         (rv[1]),
    .r3         (rv[2]),
    .r4         (rv[3]),
    .r5         (rv[4]),
    .r6         (rv[5]),
    .r7         (rv[6]),
    .r8         (rv[7]),
    .r9         (rv[8]),
    .r10        (rv[9]),
    .r11        (rv[10]),
    .r12        (rv[11]),
    .r13        (rv[12]),
    .r14        (rv[13]),
    .r15        (rv[14]),
    .r16        (rv[15]),
    .end_process(end_process),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .dump_done  (dump_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled on the falling edge, where valid/ready are settled for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(held));
      end
      hold_pend = tx_valid && !tx_ready;
      held      = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        xfers++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_frame();
    logic [7:0] cs;
    logic [7:0] hi;
    logic [7:0] lo;
    cs = '0;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 16; k++) begin
      hi = {4'h0, rv[k][11:8]};
      lo = rv[k][7:0];
      exp_q.push_back(hi);
      exp_q.push_back(lo);
      cs = cs ^ hi ^ lo;
    end
    if (EXP_LEN > 33) exp_q.push_back(cs);
  endtask

  task automatic start_frame(input string tag);
    push_frame();
    end_process = 1'b1;
    tick();
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_sync"}, 32'(tx_data), 32'hA5);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!dump_done && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(dump_done), 32'd1);
    check({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_regs();
    for (int k = 0; k < 16; k++) rv[k] = 12'($urandom);
  endtask

  initial begin
    int n;
    int base;
    rst_n       = 1'b0;
    end_process = 1'b0;
    tx_ready    = 1'b1;
    for (int k = 0; k < 16; k++) rv[k] = '0;
    tick();
    tick();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Basic frame, tx_ready held high: 33/34 back-to-back bytes.
    for (int k = 0; k < 16; k++) rv[k] = 12'(12'h101 + k);
    start_frame("basic");
    end_process = 1'b0;
    n = 0;
    while (tx_valid && n < 100) begin
      tick();
      n++;
    end
    check("basic_len", 32'(n), 32'(EXP_LEN));
    check("basic_done", 32'(dump_done), 32'd1);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_qempty", 32'(exp_q.size()), 32'd0);
    tick();
    check("basic_done_clr", 32'(dump_done), 32'd0);
    tick();

    // Snapshot isolation and ignored rise mid-frame.
    rand_regs();
    rv[0] = 12'h101;
    start_frame("snap");
    rv[0] = 12'hFFF;
    tick();
    tick();
    end_process = 1'b0;
    repeat (3) tick();
    end_process = 1'b1;
    tick();
    end_process = 1'b0;
    wait_done("snap");
    tick();
    n = 0;
    repeat (10) begin
      tick();
      if (tx_valid) n++;
    end
    check("snap_no_restart", 32'(n), 32'd0);

    // Pseudo-random backpressure.
    rand_regs();
    rand_ready = 1'b1;
    start_frame("bp");
    end_process = 1'b0;
    wait_done("bp");
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    tick();
    tick();

    // Reset after ten bytes, then a fresh full frame.
    rand_regs();
    start_frame("rst");
    end_process = 1'b0;
    base = xfers;
    n = 0;
    while (xfers - base < 10 && n < 200) begin
      tick();
      n++;
    end
    check("rst_reach10", 32'(xfers - base), 32'd10);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_data", 32'(tx_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(dump_done), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    rand_regs();
    start_frame("post_rst");
    end_process = 1'b0;
    wait_done("post_rst");
    tick();
    tick();

    // DONE holds while end_process stays high.
    rand_regs();
    start_frame("hold");
    wait_done("hold");
    n = 0;
    repeat (100) begin
      tick();
      if (dump_done) n++;
    end
    check("hold_done_cnt", 32'(n), 32'd100);
    end_process = 1'b0;
    check("hold_still", 32'(dump_done), 32'd1);
    tick();
    check("hold_exit", 32'(dump_done), 32'd0);
    tick();

`ifdef RESULT_DUMP_CHECKSUM_EN
    for (int k = 0; k < 16; k++) rv[k] = 12'hABC;
    start_frame("cs_abc");
    end_process = 1'b0;
    wait_done("cs_abc");
    tick();
    tick();
    for (int k = 0; k < 16; k++) rv[k] = '0;
    rv[0] = 12'h001;
    start_frame("cs_one");
    end_process = 1'b0;
    wait_done("cs_one");
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
